systolic_unary_matmul_array: RTL and testbench
==============================================

// Module: systolic_unary_matmul_array
// PURPOSE
//  Computes C = A x B for small unsigned integer matrices on a systolic chain of unary-binary PEs.
//  The block is the datapath core behind systolic_unary_matmul.
//  Each PE multiplies by streaming operand a as a thermometer (unary) bitstream. It adds b into a
//  binary accumulator on every '1' bit, then adds the result to the partial sum from the stage above.
//  Rows of A flow through A_COL stages, skewed one epoch apart.
// PARAMETERS
//  SIZE   2  bit width of every A/B element (unsigned)
//  A_ROW  2  rows of A, and rows of C
//  A_COL  3  columns of A = inner dimension = number of pipeline stages
//  B_ROW  3  rows of B; must equal A_COL (elaboration $error otherwise)
//  B_COL  2  columns of B, and columns of C; also PEs per stage
// PORTS
//  clk           in   1                           single clock, rising edge
//  reset_n       in   1                           asynchronous, active-low reset
//  input_valid   in   1                           start request; A and B are sampled on the accepting edge
//  A             in   [A_ROW][A_COL][SIZE]        A[i][k], packed
//  B             in   [B_ROW][B_COL][SIZE]        B[k][j], packed
//  output_ready  out  1                           C valid and stable
//  C             out  [A_ROW][B_COL][2*SIZE+A_COL]  C[i][j], packed, unsigned
// BEHAVIOUR
//  - Reset: state=IDLE, output_ready=0, C=0, all accumulators and intermediate_data_cur=0.
//  - Epoch length M = 2**SIZE-1 cycles. A unary stream of value a is 1 for the first a cycles of the epoch, then 0.
//  - FSM IDLE->RUN: on input_valid=1 in IDLE or DONE. Latch A/B, clear C and output_ready, start epoch 0.
//  - FSM RUN->DONE: after E = A_ROW+A_COL-1 epochs (E*M cycles). On that edge, output_ready=1.
//  - FSM in DONE: stays there with C held until the next accepted input_valid.
//  - input_valid in RUN is ignored; the latched operands are unaffected.
//  - Stage k (1..A_COL) processes row i = e-(k-1) during epoch e when 0<=i<A_ROW, otherwise it idles.
//  - PE(k,j) each cycle: acc += (ustream(A[i][k-1]) ? B[k-1][j] : 0).
//  - PE(k,j) at epoch end: intermediate_data_cur[k][j] = intermediate_data_cur[k-1][j] + acc, then acc clears.
//  - intermediate_data_cur[0][*] is constant 0.
//  - When stage A_COL finishes row i, C[i][*] is written from intermediate_data_cur[A_COL][*].
//  - Widths: acc is 2*SIZE bits. Partial sums and C are 2*SIZE+A_COL bits; no overflow is possible.
//  - Zero operand: a=0 yields a product of 0 with no timing change. Latency is data-independent.
//  - Reset mid-RUN aborts immediately to the reset state; no partial C is retained.
//  - The internal array is named intermediate_data_cur[0..A_COL][0..B_COL-1] so benches can probe it hierarchically.
// CONFIGURATION
//  UMM_BUSY_PORT_EN: when defined, adds output port busy (1 bit), high exactly while state==RUN.
//  busy resets to 0. Without the macro the port does not exist and all other behaviour is identical.
// TESTING
//  - Reset: assert reset_n=0 at any time -> output_ready=0, C all 0 asynchronously.
//  - Defaults, A=[[1,2,3],[3,1,2]], B=[[2,2],[1,2],[3,1]], input_valid pulsed 1 cycle:
//    output_ready rises 12 cycles later; C=[[13,9],[13,10]], held.
//  - Max values A=all 3, B=all 3: C all 27, no overflow. All zeros: C all 0, same 12-cycle latency.
//  - input_valid held high during RUN with changed A/B -> result still matches the first operands.
//  - reset_n pulsed low at cycle 5 of RUN -> IDLE, C=0; a restart then gives the correct result.
//  - Back-to-back jobs: a new input_valid in DONE clears output_ready next cycle; the second result is correct.

Source files
------------

// File: rtl/systolic_unary_matmul_array.sv
// Systolic unary-binary matrix multiplier: C = A x B, rows of A skewed one epoch per stage.
// Optional `define UMM_BUSY_PORT_EN adds a busy output that is high while a job is running.
module systolic_unary_matmul_array #(
    parameter int SIZE  = 2,
    parameter int A_ROW = 2,
    parameter int A_COL = 3,
    parameter int B_ROW = 3,
    parameter int B_COL = 2
) (
    input  logic                                             clk,
    input  logic                                             reset_n,
    input  logic                                             input_valid,
    input  logic [A_ROW-1:0][A_COL-1:0][SIZE-1:0]            A,
    input  logic [B_ROW-1:0][B_COL-1:0][SIZE-1:0]            B,
    output logic                                             output_ready,
`ifdef UMM_BUSY_PORT_EN
    output logic                                             busy,
`endif
    output logic [A_ROW-1:0][B_COL-1:0][2*SIZE+A_COL-1:0]    C
);

    localparam int M    = 2**SIZE - 1;
    localparam int E    = A_ROW + A_COL - 1;
    localparam int AW   = 2*SIZE;
    localparam int CW   = 2*SIZE + A_COL;
    localparam int EP_W = $clog2(E + 1);
    localparam logic [SIZE-1:0] CYC_LAST = SIZE'(M - 1);
    localparam logic [EP_W-1:0] EP_LAST  = EP_W'(E - 1);

    generate
        if (B_ROW != A_COL) begin : g_dim_check
            $error("B_ROW (%0d) must equal A_COL (%0d)", B_ROW, A_COL);
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                                         state_q, state_d;
    logic [SIZE-1:0]                                cyc_q, cyc_d;
    logic [EP_W-1:0]                                epoch_q, epoch_d;
    logic [A_ROW-1:0][A_COL-1:0][SIZE-1:0]          a_q, a_d;
    logic [B_ROW-1:0][B_COL-1:0][SIZE-1:0]          b_q, b_d;
    logic [A_ROW-1:0][B_COL-1:0][CW-1:0]            c_q, c_d;
    logic                                           ready_q, ready_d;
    logic [AW-1:0]                                  acc_q [1:A_COL][0:B_COL-1];
    logic [AW-1:0]                                  acc_d [1:A_COL][0:B_COL-1];
    logic [CW-1:0]                                  intermediate_data_cur [0:A_COL][0:B_COL-1];
    logic [CW-1:0]                                  intermediate_data_d   [0:A_COL][0:B_COL-1];

    // Thermometer code: value a is 1 during the first a cycles of the epoch.
    function automatic logic ustream(input logic [SIZE-1:0] a, input logic [SIZE-1:0] cyc);
        return cyc < a;
    endfunction

    always_comb begin
        logic [AW-1:0] sum;
        sum                 = '0;
        state_d             = state_q;
        cyc_d               = cyc_q;
        epoch_d             = epoch_q;
        a_d                 = a_q;
        b_d                 = b_q;
        c_d                 = c_q;
        ready_d             = ready_q;
        acc_d               = acc_q;
        intermediate_data_d = intermediate_data_cur;
        for (int j = 0; j < B_COL; j++) begin
            intermediate_data_d[0][j] = '0;
        end

        case (state_q)
            IDLE, DONE: begin
                if (input_valid) begin
                    a_d     = A;
                    b_d     = B;
                    c_d     = '0;
                    ready_d = 1'b0;
                    cyc_d   = '0;
                    epoch_d = '0;
                    for (int k = 1; k <= A_COL; k++) begin
                        for (int j = 0; j < B_COL; j++) begin
                            acc_d[k][j] = '0;
                        end
                    end
                    state_d = RUN;
                end
            end
            RUN: begin
                // Stage k works on row r exactly when the epoch equals r + k - 1.
                for (int k = 1; k <= A_COL; k++) begin
                    for (int r = 0; r < A_ROW; r++) begin
                        if (epoch_q == EP_W'(r + k - 1)) begin
                            for (int j = 0; j < B_COL; j++) begin
                                sum = acc_q[k][j] +
                                      (ustream(a_q[r][k-1], cyc_q) ? AW'(b_q[k-1][j]) : '0);
                                if (cyc_q == CYC_LAST) begin
                                    intermediate_data_d[k][j] =
                                        intermediate_data_cur[k-1][j] + CW'(sum);
                                    acc_d[k][j] = '0;
                                    if (k == A_COL) begin
                                        c_d[r][j] = intermediate_data_d[k][j];
                                    end
                                end else begin
                                    acc_d[k][j] = sum;
                                end
                            end
                        end
                    end
                end
                if (cyc_q == CYC_LAST) begin
                    cyc_d = '0;
                    if (epoch_q == EP_LAST) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                    end else begin
                        epoch_d = epoch_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            epoch_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            ready_q <= 1'b0;
            for (int k = 1; k <= A_COL; k++) begin
                for (int j = 0; j < B_COL; j++) begin
                    acc_q[k][j] <= '0;
                end
            end
            for (int k = 0; k <= A_COL; k++) begin
                for (int j = 0; j < B_COL; j++) begin
                    intermediate_data_cur[k][j] <= '0;
                end
            end
        end else begin
            state_q               <= state_d;
            cyc_q                 <= cyc_d;
            epoch_q               <= epoch_d;
            a_q                   <= a_d;
            b_q                   <= b_d;
            c_q                   <= c_d;
            ready_q               <= ready_d;
            acc_q                 <= acc_d;
            intermediate_data_cur <= intermediate_data_d;
        end
    end

    assign output_ready = ready_q;
    assign C            = c_q;
`ifdef UMM_BUSY_PORT_EN
    assign busy         = (state_q == RUN);
`endif

endmodule

// File: tb/tb_systolic_unary_matmul_array.sv
// Self-checking bench for systolic_unary_matmul_array against a plain matrix-product model.
module tb_systolic_unary_matmul_array;

    localparam int SIZE  = 2;
    localparam int A_ROW = 2;
    localparam int A_COL = 3;
    localparam int B_COL = 2;
    localparam int CW    = 2*SIZE + A_COL;
    localparam int LAT   = (A_ROW + A_COL - 1) * (2**SIZE - 1);

    typedef logic [A_ROW-1:0][A_COL-1:0][SIZE-1:0] a_t;
    typedef logic [A_COL-1:0][B_COL-1:0][SIZE-1:0] b_t;
    typedef logic [A_ROW-1:0][B_COL-1:0][CW-1:0]   c_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic input_valid = 1'b0;
    a_t   A_in = '0;
    b_t   B_in = '0;
    logic output_ready;
    c_t   C_out;

    int vectors = 0;
    int miscompares = 0;

    systolic_unary_matmul_array dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .input_valid  (input_valid),
        .A            (A_in),
        .B            (B_in),
        .output_ready (output_ready),
        .C            (C_out)
    );

    always #5 clk = ~clk;

    function automatic c_t model(input a_t a, input b_t b);
        c_t r;
        int s;
        r = '0;
        for (int i = 0; i < A_ROW; i++) begin
            for (int j = 0; j < B_COL; j++) begin
                s = 0;
                for (int k = 0; k < A_COL; k++) s += int'(a[i][k]) * int'(b[k][j]);
                r[i][j] = CW'(s);
            end
        end
        return r;
    endfunction

    function automatic a_t rand_a();
        a_t r;
        for (int i = 0; i < A_ROW; i++)
            for (int k = 0; k < A_COL; k++) r[i][k] = SIZE'($urandom_range(0, 3));
        return r;
    endfunction

    function automatic b_t rand_b();
        b_t r;
        for (int k = 0; k < A_COL; k++)
            for (int j = 0; j < B_COL; j++) r[k][j] = SIZE'($urandom_range(0, 3));
        return r;
    endfunction

    function automatic a_t mk_a(input int v [A_ROW][A_COL]);
        a_t r;
        for (int i = 0; i < A_ROW; i++)
            for (int k = 0; k < A_COL; k++) r[i][k] = SIZE'(v[i][k]);
        return r;
    endfunction

    function automatic b_t mk_b(input int v [A_COL][B_COL]);
        b_t r;
        for (int k = 0; k < A_COL; k++)
            for (int j = 0; j < B_COL; j++) r[k][j] = SIZE'(v[k][j]);
        return r;
    endfunction

    // Drives one accepted request and waits (bounded) for output_ready; no checking here.
    task automatic run_job(input a_t a, input b_t b, output int lat);
        @(negedge clk);
        A_in = a;
        B_in = b;
        input_valid = 1'b1;
        @(posedge clk);
        #1;
        input_valid = 1'b0;
        lat = 0;
        while (output_ready !== 1'b1 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        vectors++;
        if (output_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 0", output_ready);
        end
        vectors++;
        if (C_out !== '0) begin
            miscompares++;
            $display("FAIL reset_C: got %h want 0", C_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_spec_example();
        int lat;
        int av [A_ROW][A_COL] = '{'{1, 2, 3}, '{3, 1, 2}};
        int bv [A_COL][B_COL] = '{'{2, 2}, '{1, 2}, '{3, 1}};
        int ex [A_ROW][B_COL] = '{'{13, 9}, '{13, 10}};
        run_job(mk_a(av), mk_b(bv), lat);
        vectors++;
        if (lat !== LAT) begin
            miscompares++;
            $display("FAIL example_latency: got %0d want %0d", lat, LAT);
        end
        for (int i = 0; i < A_ROW; i++)
            for (int j = 0; j < B_COL; j++) begin
                vectors++;
                if (int'(C_out[i][j]) !== ex[i][j]) begin
                    miscompares++;
                    $display("FAIL example_C[%0d][%0d]: got %0d want %0d", i, j, C_out[i][j], ex[i][j]);
                end
            end
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (output_ready !== 1'b1 || int'(C_out[1][1]) !== ex[1][1]) begin
            miscompares++;
            $display("FAIL example_hold: got ready=%b C11=%0d want ready=1 C11=%0d",
                     output_ready, C_out[1][1], ex[1][1]);
        end
    endtask

    task automatic test_extremes();
        int lat;
        a_t a;
        b_t b;
        for (int pass = 0; pass < 2; pass++) begin
            a = (pass == 0) ? '1 : '0;
            b = (pass == 0) ? '1 : '0;
            run_job(a, b, lat);
            vectors++;
            if (lat !== LAT) begin
                miscompares++;
                $display("FAIL extreme%0d_latency: got %0d want %0d", pass, lat, LAT);
            end
            for (int i = 0; i < A_ROW; i++)
                for (int j = 0; j < B_COL; j++) begin
                    vectors++;
                    if (int'(C_out[i][j]) !== ((pass == 0) ? 27 : 0)) begin
                        miscompares++;
                        $display("FAIL extreme%0d_C[%0d][%0d]: got %0d want %0d", pass, i, j,
                                 C_out[i][j], (pass == 0) ? 27 : 0);
                    end
                end
        end
    endtask

    task automatic test_random();
        int lat;
        a_t a;
        b_t b;
        c_t ex;
        for (int n = 0; n < 8; n++) begin
            a = rand_a();
            b = rand_b();
            ex = model(a, b);
            run_job(a, b, lat);
            vectors++;
            if (lat !== LAT) begin
                miscompares++;
                $display("FAIL random%0d_latency: got %0d want %0d", n, lat, LAT);
            end
            vectors++;
            if (C_out !== ex) begin
                miscompares++;
                $display("FAIL random%0d_C: got %h want %h", n, C_out, ex);
            end
        end
    endtask

    task automatic test_ignore_valid_in_run();
        int lat;
        a_t a;
        b_t b;
        c_t ex;
        a = rand_a();
        b = rand_b();
        ex = model(a, b);
        @(negedge clk);
        A_in = a;
        B_in = b;
        input_valid = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        repeat (8) begin
            A_in = ~a;
            B_in = rand_b();
            @(posedge clk);
            #1;
            lat++;
        end
        input_valid = 1'b0;
        while (output_ready !== 1'b1 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        vectors++;
        if (lat !== LAT) begin
            miscompares++;
            $display("FAIL ignore_latency: got %0d want %0d", lat, LAT);
        end
        vectors++;
        if (C_out !== ex) begin
            miscompares++;
            $display("FAIL ignore_C: got %h want %h", C_out, ex);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int av [A_ROW][A_COL] = '{'{1, 2, 3}, '{3, 1, 2}};
        int bv [A_COL][B_COL] = '{'{2, 2}, '{1, 2}, '{3, 1}};
        c_t ex;
        ex = model(mk_a(av), mk_b(bv));
        @(negedge clk);
        A_in = mk_a(av);
        B_in = mk_b(bv);
        input_valid = 1'b1;
        @(posedge clk);
        #1;
        input_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (output_ready !== 1'b0 || C_out !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got ready=%b C=%h want ready=0 C=0", output_ready, C_out);
        end
        vectors++;
        if (dut.intermediate_data_cur[1][0] !== '0) begin
            miscompares++;
            $display("FAIL midreset_partial: got %0d want 0", dut.intermediate_data_cur[1][0]);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if (output_ready !== 1'b0 || C_out !== '0) begin
            miscompares++;
            $display("FAIL midreset_idle: got ready=%b C=%h want ready=0 C=0", output_ready, C_out);
        end
        run_job(mk_a(av), mk_b(bv), lat);
        vectors++;
        if (lat !== LAT || C_out !== ex) begin
            miscompares++;
            $display("FAIL midreset_restart: got lat=%0d C=%h want lat=%0d C=%h", lat, C_out, LAT, ex);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        a_t a;
        b_t b;
        c_t ex;
        a = rand_a();
        b = rand_b();
        ex = model(a, b);
        vectors++;
        if (output_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_precondition: got ready=%b want 1", output_ready);
        end
        @(negedge clk);
        A_in = a;
        B_in = b;
        input_valid = 1'b1;
        @(posedge clk);
        #1;
        input_valid = 1'b0;
        vectors++;
        if (output_ready !== 1'b0 || C_out !== '0) begin
            miscompares++;
            $display("FAIL b2b_clear: got ready=%b C=%h want ready=0 C=0", output_ready, C_out);
        end
        lat = 0;
        while (output_ready !== 1'b1 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        vectors++;
        if (lat !== LAT || C_out !== ex) begin
            miscompares++;
            $display("FAIL b2b_result: got lat=%0d C=%h want lat=%0d C=%h", lat, C_out, LAT, ex);
        end
    endtask

    initial begin
        #12;
        test_reset();
        test_spec_example();
        test_extremes();
        test_random();
        test_ignore_valid_in_run();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
